// File: rtl/soc_rr_arb.sv
// soc_rr_arb: round-robin one-hot grant selector.
// Search starts one past the last granted index and wraps modulo N.
module soc_rr_arb #(
    parameter int N   = 2,
    parameter int LGW = 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [LGW-1:0] i_last,
    output logic [N-1:0]   o_gnt
);

    logic           w_found;
    logic [LGW-1:0] w_idx;

    // walk indices last+1 .. last+N, first requester wins
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = LGW'((int'(i_last) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_spram_arb.sv
// soc_spram_arb: N-port round-robin arbiter in front of a single SPRAM.
// ISSUE drives the SPRAM combinationally; COMPLETE acks one cycle later.
module soc_spram_arb #(
    parameter int N_PORTS = 2,
    parameter int AW      = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PORTS*AW-1:0] req_addr,
    input  logic [N_PORTS*32-1:0] req_wdata,
    input  logic [N_PORTS*4-1:0]  req_wmsk,
    input  logic [N_PORTS-1:0]    req_we,
    input  logic [N_PORTS-1:0]    req_valid,
    output logic [N_PORTS-1:0]    req_ack,
    output logic [31:0]           req_rdata,
    output logic [AW-1:0]         spram_addr,
    output logic [31:0]           spram_wdata,
    output logic [3:0]            spram_wmsk,
    output logic                  spram_we,
    input  logic [31:0]           spram_rdata
);

    localparam int LGW = (N_PORTS > 2) ? 2 : 1;

    logic [LGW-1:0]     r_last;
    logic [N_PORTS-1:0] r_cmp_gnt;

    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_gnt;
    logic [LGW-1:0]     w_gidx;
    logic               w_any;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wmsk;

    // the port being acked still holds valid; keep it out of this round
    assign w_req = rst_n ? (req_valid & ~r_cmp_gnt) : '0;

    soc_rr_arb #(
        .N   (N_PORTS),
        .LGW (LGW)
    ) u_arb (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // route the granted port's command onto the SPRAM bus
    always_comb begin
        w_any   = 1'b0;
        w_gidx  = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_wmsk  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_gnt[i]) begin
                w_any   = 1'b1;
                w_gidx  = LGW'(i);
                w_we    = req_we[i];
                w_addr  = req_addr[i*AW +: AW];
                w_wdata = req_wdata[i*32 +: 32];
                w_wmsk  = req_wmsk[i*4 +: 4];
            end
        end
    end

    assign spram_addr  = w_addr;
    assign spram_wdata = w_wdata;
    assign spram_wmsk  = w_any ? w_wmsk : 4'h0;
    assign spram_we    = w_any & w_we;

    // COMPLETE stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmp_gnt <= '0;
            r_last    <= LGW'(N_PORTS - 1);
        end else begin
            r_cmp_gnt <= w_gnt;
            if (w_any) begin
                r_last <= w_gidx;
            end
        end
    end

    assign req_ack   = r_cmp_gnt & {N_PORTS{rst_n}};
    assign req_rdata = spram_rdata;

endmodule

// File: tb/tb_soc_spram_arb.sv
// tb_soc_spram_arb: directed checks of the SPRAM arbiter with 4 ports.
// A behavioural SPRAM with one-cycle read latency sits behind the DUT.
module tb_soc_spram_arb;

    localparam int NP = 4;
    localparam int AW = 14;

    logic             clk;
    logic             rst_n;
    logic [NP*AW-1:0] req_addr;
    logic [NP*32-1:0] req_wdata;
    logic [NP*4-1:0]  req_wmsk;
    logic [NP-1:0]    req_we;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_ack;
    logic [31:0]      req_rdata;
    logic [AW-1:0]    spram_addr;
    logic [31:0]      spram_wdata;
    logic [3:0]       spram_wmsk;
    logic             spram_we;
    logic [31:0]      spram_rdata;

    logic [31:0] mem [0:(1<<AW)-1];

    int n_tests;
    int n_fail;

    soc_spram_arb #(
        .N_PORTS (NP),
        .AW      (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmsk    (req_wmsk),
        .req_we      (req_we),
        .req_valid   (req_valid),
        .req_ack     (req_ack),
        .req_rdata   (req_rdata),
        .spram_addr  (spram_addr),
        .spram_wdata (spram_wdata),
        .spram_wmsk  (spram_wmsk),
        .spram_we    (spram_we),
        .spram_rdata (spram_rdata)
    );

    always #5 clk = ~clk;

    // SPRAM: byte-masked write, registered read
    always @(posedge clk) begin
        if (spram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (spram_wmsk[b]) begin
                    mem[spram_addr][b*8 +: 8] <= spram_wdata[b*8 +: 8];
                end
            end
        end
        spram_rdata <= mem[spram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        req_we[p]             = we;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*32 +: 32] = d;
        req_wmsk[p*4 +: 4]    = m;
    endtask

    logic [3:0] exp4 [8];

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wmsk    = '0;
        req_we      = '0;
        req_valid   = '0;
        spram_rdata = '0;

        // reset forces the SPRAM idle even with all ports requesting writes
        for (int p = 0; p < NP; p++) drv(p, 1'b1, 14'h30, 32'hFFFF_FFFF, 4'hF);
        req_valid = 4'hF;
        #1;
        chk("rst_we", {31'd0, spram_we}, 32'd0);
        chk("rst_wmsk", {28'd0, spram_wmsk}, 32'd0);
        chk("rst_ack", {28'd0, req_ack}, 32'd0);
        tick();
        chk("rst_ack2", {28'd0, req_ack}, 32'd0);
        chk("rst_we2", {31'd0, spram_we}, 32'd0);
        req_valid = '0;
        req_we    = '0;
        rst_n     = 1'b1;
        tick();
        chk("idle_ack", {28'd0, req_ack}, 32'd0);

        // port0 full write, then port1 reads it back
        drv(0, 1'b1, 14'h10, 32'hDEAD_BEEF, 4'hF);
        req_valid = 4'b0001;
        #1;
        chk("wr_we", {31'd0, spram_we}, 32'd1);
        chk("wr_addr", {18'd0, spram_addr}, 32'h10);
        chk("wr_wdata", spram_wdata, 32'hDEAD_BEEF);
        chk("wr_wmsk", {28'd0, spram_wmsk}, 32'hF);
        tick();
        chk("wr_ack", {28'd0, req_ack}, 32'b0001);
        chk("excl_we", {31'd0, spram_we}, 32'd0);
        chk("excl_wmsk", {28'd0, spram_wmsk}, 32'd0);
        drv(1, 1'b0, 14'h10, 32'h0, 4'h0);
        req_valid = 4'b0010;
        #1;
        chk("rd_addr", {18'd0, spram_addr}, 32'h10);
        chk("rd_we", {31'd0, spram_we}, 32'd0);
        tick();
        chk("rd_ack", {28'd0, req_ack}, 32'b0010);
        chk("rd_data", req_rdata, 32'hDEAD_BEEF);
        req_valid = '0;
        tick();
        chk("rd_ack_off", {28'd0, req_ack}, 32'd0);

        // byte write merges into existing word
        drv(0, 1'b1, 14'h20, 32'h1122_3344, 4'hF);
        req_valid = 4'b0001;
        tick();
        chk("pre_ack", {28'd0, req_ack}, 32'b0001);
        req_valid = '0;
        tick();
        drv(0, 1'b1, 14'h20, 32'h0000_AB00, 4'h2);
        req_valid = 4'b0001;
        #1;
        chk("bw_wmsk", {28'd0, spram_wmsk}, 32'h2);
        chk("bw_we", {31'd0, spram_we}, 32'd1);
        tick();
        chk("bw_ack", {28'd0, req_ack}, 32'b0001);
        req_valid = '0;
        tick();
        drv(1, 1'b0, 14'h20, 32'h0, 4'h0);
        req_valid = 4'b0010;
        tick();
        chk("bw_rd_ack", {28'd0, req_ack}, 32'b0010);
        chk("bw_rd_data", req_rdata, 32'h1122_AB44);
        req_valid = '0;
        tick();

        // two ports contending from reset alternate with an ack every cycle
        rst_n = 1'b0;
        tick();
        drv(0, 1'b0, 14'h10, 32'h0, 4'h0);
        drv(1, 1'b0, 14'h20, 32'h0, 4'h0);
        req_valid = 4'b0011;
        rst_n     = 1'b1;
        #1;
        chk("alt_first_addr", {18'd0, spram_addr}, 32'h10);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("alt_ack%0d", i), {28'd0, req_ack}, 32'b0001);
                chk($sformatf("alt_data%0d", i), req_rdata, 32'hDEAD_BEEF);
            end else begin
                chk($sformatf("alt_ack%0d", i), {28'd0, req_ack}, 32'b0010);
                chk($sformatf("alt_data%0d", i), req_rdata, 32'h1122_AB44);
            end
        end
        req_valid = '0;
        tick();
        chk("drop_no_ack", {28'd0, req_ack}, 32'd0);

        // lone requester is served every other cycle
        drv(2, 1'b0, 14'h10, 32'h0, 4'h0);
        req_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("solo_ack%0d", i), {28'd0, req_ack},
                (i % 2 == 0) ? 32'b0100 : 32'd0);
        end
        req_valid = '0;
        tick();
        chk("solo_off", {28'd0, req_ack}, 32'd0);

        // four ports: pointer sits at 2, so order is 3,0,1,2,...
        drv(3, 1'b0, 14'h20, 32'h0, 4'h0);
        exp4 = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr4_ack%0d", i), {28'd0, req_ack}, {28'd0, exp4[i]});
        end
        req_valid = '0;
        req_we    = 4'hF;
        #1;
        chk("idle4_we", {31'd0, spram_we}, 32'd0);
        chk("idle4_wmsk", {28'd0, spram_wmsk}, 32'd0);
        tick();
        chk("idle4_ack", {28'd0, req_ack}, 32'd0);
        req_we = '0;

        // reset lands on a port2 write grant; it must vanish
        drv(2, 1'b1, 14'h30, 32'hCAFE_F00D, 4'hF);
        req_valid = 4'b0100;
        #1;
        chk("p2_we", {31'd0, spram_we}, 32'd1);
        chk("p2_addr", {18'd0, spram_addr}, 32'h30);
        rst_n = 1'b0;
        #1;
        chk("p2_rst_we", {31'd0, spram_we}, 32'd0);
        chk("p2_rst_wmsk", {28'd0, spram_wmsk}, 32'd0);
        tick();
        chk("p2_rst_ack", {28'd0, req_ack}, 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("p2_post_ack", {28'd0, req_ack}, 32'd0);
        drv(2, 1'b0, 14'h20, 32'h0, 4'h0);
        req_valid = 4'b0101;
        #1;
        chk("post_rst_addr", {18'd0, spram_addr}, 32'h10);
        tick();
        chk("post_rst_ack0", {28'd0, req_ack}, 32'b0001);
        tick();
        chk("post_rst_ack2", {28'd0, req_ack}, 32'b0100);
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_spram_arb.md
SOC_SPRAM_ARB -- requirements
Module: soc_spram_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, giving the number of requesters (legal range 2..4).
REQ-002 SHALL have parameter AW, default 14, giving the SPRAM word-address width (14 => 64k, 15 => 128k).
REQ-003 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 SHALL have port req_addr, input, N_PORTS*AW bits, packed per-port word addresses (port i at bits [i*AW +: AW]).
REQ-006 SHALL have port req_wdata, input, N_PORTS*32 bits, packed per-port write data.
REQ-007 SHALL have port req_wmsk, input, N_PORTS*4 bits, packed per-port byte-write masks, 1 = byte written.
REQ-008 SHALL have port req_we, input, N_PORTS bits, per-port write enable (0 = read).
REQ-009 SHALL have port req_valid, input, N_PORTS bits, per-port request, held high until the matching req_ack.
REQ-010 SHALL have port req_ack, output, N_PORTS bits, one-cycle completion pulse per port.
REQ-011 SHALL have port req_rdata, output, 32 bits, read data shared by all ports, valid only in the cycle of req_ack.
REQ-012 SHALL have port spram_addr, output, AW bits, SPRAM word address.
REQ-013 SHALL have port spram_wdata, output, 32 bits, SPRAM write data.
REQ-014 SHALL have port spram_wmsk, output, 4 bits, SPRAM byte mask.
REQ-015 SHALL have port spram_we, output, 1 bit, SPRAM write strobe.
REQ-016 SHALL have port spram_rdata, input, 32 bits, SPRAM read data, valid one cycle after the address is presented.

Function
REQ-017 SHALL use a two-stage pipeline: ISSUE (grant plus SPRAM command, combinational from request and arbiter state) and COMPLETE (registered grant plus ack).
REQ-018 SHALL present the granted port's addr, wdata and wmsk on the SPRAM outputs in the ISSUE cycle.
REQ-019 SHALL drive spram_we = req_we of the granted port AND a grant exists.
REQ-020 SHALL, when no port is granted, drive spram_we = 0 and spram_wmsk = 0, with addr/wdata don't-care.
REQ-021 SHALL pulse req_ack[g] for exactly one cycle in the cycle after port g is granted (fixed latency 1), for both reads and writes.
REQ-022 SHALL pass req_rdata = spram_rdata unregistered in the ack cycle.
REQ-023 SHALL exclude from arbitration in the COMPLETE cycle the port being acked, so its still-high valid is not granted twice.
REQ-024 SHALL otherwise be able to grant another port in the same cycle, giving one access per clock under contention.
REQ-025 SHALL arbitrate round-robin: the search starts at (last_grant+1) mod N_PORTS.
REQ-026 SHALL update last_grant only when a grant occurs.
REQ-027 SHALL reset last_grant to N_PORTS-1, so port 0 wins the first contention.
REQ-028 SHALL bound waiting: a continuously valid port is granted within N_PORTS issue slots.
REQ-029 SHALL grant at most one port per cycle (grant vector one-hot or zero).
REQ-030 SHALL ignore a requester that drops valid before being granted; no ack is produced for it.
REQ-031 SHALL treat a single requester that holds valid continuously as requesting every other cycle (grant, ack, grant ...).

Reset
REQ-032 SHALL, while rst_n = 0 at a clk edge, clear the COMPLETE-stage registers and set last_grant = N_PORTS-1.
REQ-033 SHALL, while rst_n = 0, force req_ack = 0, spram_we = 0 and spram_wmsk = 0, and make no grant.
REQ-034 SHALL discard an access issued in the cycle reset asserts; no ack follows it after reset release.

Structure
REQ-035 SHALL be a single module with no shared package; the only constants are N_PORTS and AW.
REQ-036 SHALL place round-robin selection in one natural sub-module, soc_rr_arb (inputs: request vector, last_grant; output: one-hot grant), reusable elsewhere.

Verification
REQ-037 SHALL cover: port0 write addr 0x0010, data 0xDEADBEEF, wmsk 0xF; then port1 read 0x0010 -> port0 ack one cycle after grant; port1 ack with rdata 0xDEADBEEF.
REQ-038 SHALL cover: byte write wmsk 0x2, data 0x0000AB00 onto 0x11223344 at 0x0020 -> a later read returns 0x1122AB44.
REQ-039 SHALL cover: ports 0 and 1 both valid from reset for 8 cycles -> grants alternate 0,1,0,1 with one ack every cycle from cycle 2.
REQ-040 SHALL cover: single port holds valid 6 cycles -> acks on cycles 2, 4, 6, never two consecutive.
REQ-041 SHALL cover: N_PORTS=4, all valid -> each port acked once in any 4 consecutive ack cycles; spram_we=0 on idle cycles.
REQ-042 SHALL cover: rst_n low in the cycle of a port2 grant -> no req_ack after release, and port0 wins the next contention.
